// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor: tagged BTB with a 2-bit saturating counter per entry.
// Zero-cycle fetch lookup, EX-stage training, mispredict detection and fetch redirect.
module branch_predict_unit #(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  output logic        pred_taken_if,
  output logic [31:0] pred_target_if,
  input  logic        branch_ex,
  input  logic        stall_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] target_ex,
  input  logic        taken_ex,
  input  logic        pred_taken_ex,
  input  logic [31:0] pred_target_ex,
  output logic        mispredict_ex,
  output logic [31:0] redirect_pc_ex,
  output logic [31:0] mispredict_cnt
);
  localparam int DEPTH  = 1 << IDX_W;
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [29:0]      target_q [DEPTH];
  logic [1:0]       cnt_q    [DEPTH];
  logic [31:0]      mis_cnt_q;
  logic [31:0]      mis_cnt_d;

  logic [IDX_W-1:0] idx_if_s;
  logic [TAG_W-1:0] tag_if_s;
  logic             hit_if_s;
  logic [IDX_W-1:0] idx_ex_s;
  logic [TAG_W-1:0] tag_ex_s;
  logic             hit_ex_s;
  logic             upd_s;
  logic [1:0]       cnt_upd_s;
  logic             unused_bits_s;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] r;
    if (up) begin
      r = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      r = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return r;
  endfunction

  assign idx_if_s = pc_if[IDX_W+1:2];
  assign tag_if_s = pc_if[TAG_HI:TAG_LO];
  assign idx_ex_s = pc_ex[IDX_W+1:2];
  assign tag_ex_s = pc_ex[TAG_HI:TAG_LO];
  assign unused_bits_s = ^{pc_if[1:0], pc_if[31:TAG_HI+1], pc_ex[1:0],
                           pc_ex[31:TAG_HI+1], target_ex[1:0]};

  // Fetch-side lookup; reads the array state as it was before this cycle's write.
  always_comb begin
    hit_if_s = valid_q[idx_if_s] && (tag_q[idx_if_s] == tag_if_s);
    if (hit_if_s && cnt_q[idx_if_s][1]) begin
      pred_taken_if  = 1'b1;
      pred_target_if = {target_q[idx_if_s], 2'b00};
    end else begin
      pred_taken_if  = 1'b0;
      pred_target_if = pc_if + 32'd4;
    end
  end

  // EX-side resolution: hit check, trained counter, mispredict and redirect.
  always_comb begin
    upd_s          = branch_ex & ~stall_ex;
    hit_ex_s       = valid_q[idx_ex_s] && (tag_q[idx_ex_s] == tag_ex_s);
    cnt_upd_s      = sat_step(cnt_q[idx_ex_s], taken_ex);
    mispredict_ex  = upd_s & ((taken_ex != pred_taken_ex) |
                              (taken_ex & pred_taken_ex & (pred_target_ex != target_ex)));
    redirect_pc_ex = taken_ex ? target_ex : pc_ex + 32'd4;
    if (mispredict_ex && (mis_cnt_q != 32'hFFFF_FFFF)) begin
      mis_cnt_d = mis_cnt_q + 32'd1;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Table write: train on a hit, allocate only on a taken miss; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 30'd0;
        cnt_q[i]    <= CNT_INIT;
      end
    end else if (upd_s) begin
      if (hit_ex_s) begin
        cnt_q[idx_ex_s] <= cnt_upd_s;
        if (taken_ex) begin
          target_q[idx_ex_s] <= target_ex[31:2];
        end
      end else if (taken_ex) begin
        valid_q[idx_ex_s]  <= 1'b1;
        tag_q[idx_ex_s]    <= tag_ex_s;
        target_q[idx_ex_s] <= target_ex[31:2];
        cnt_q[idx_ex_s]    <= 2'b10;
      end
    end
  end

  // Saturating mispredict performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt_q <= 32'd0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized plus directed bench for branch_predict_unit against a behavioural predictor model.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        branch_ex;
  logic        stall_ex;
  logic [31:0] pc_ex;
  logic [31:0] target_ex;
  logic        taken_ex;
  logic        pred_taken_ex;
  logic [31:0] pred_target_ex;
  logic        mispredict_ex;
  logic [31:0] redirect_pc_ex;
  logic [31:0] mispredict_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one record per table slot, counter as a plain integer 0..3.
  bit          m_valid [64];
  int          m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  logic [31:0] m_mis;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .pred_taken_if(pred_taken_if),
    .pred_target_if(pred_target_if), .branch_ex(branch_ex), .stall_ex(stall_ex),
    .pc_ex(pc_ex), .target_ex(target_ex), .taken_ex(taken_ex),
    .pred_taken_ex(pred_taken_ex), .pred_target_ex(pred_target_ex),
    .mispredict_ex(mispredict_ex), .redirect_pc_ex(redirect_pc_ex),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd64);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 8) % 32'd256);
  endfunction

  function automatic logic model_taken(input logic [31:0] pc);
    int s = slot_of(pc);
    return m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_cnt[s] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_taken(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
  endfunction

  // One clock: drive at negedge, check before the edge, advance the model at the edge.
  task automatic cyc(input logic r, input logic [31:0] pif, input logic br, input logic st,
                     input logic [31:0] pex, input logic [31:0] tex, input logic tk,
                     input logic ptk, input logic [31:0] ptex);
    logic mp;
    int   s;
    rst = r; pc_if = pif; branch_ex = br; stall_ex = st; pc_ex = pex;
    target_ex = tex; taken_ex = tk; pred_taken_ex = ptk; pred_target_ex = ptex;
    mp = br && !st && ((tk != ptk) || (tk && ptk && (ptex != tex)));
    #2;
    if (!r) begin
      check_eq("pred_taken", {31'd0, pred_taken_if}, {31'd0, model_taken(pif)});
      check_eq("pred_target", pred_target_if, model_target(pif));
      check_eq("mispredict", {31'd0, mispredict_ex}, {31'd0, mp});
      check_eq("redirect", redirect_pc_ex, tk ? tex : pex + 32'd4);
      check_eq("mis_cnt", mispredict_cnt, m_mis);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_cnt[i] = 1;
      end
      m_mis = 32'd0;
    end else begin
      if (mp && (m_mis != 32'hFFFF_FFFF)) m_mis = m_mis + 32'd1;
      if (br && !st) begin
        s = slot_of(pex);
        if (m_valid[s] && (m_tag[s] == tag_of(pex))) begin
          if (tk) begin
            m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
            m_tgt[s] = tex & 32'hFFFF_FFFC;
          end else begin
            m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
          end
        end else if (tk) begin
          m_valid[s] = 1'b1; m_tag[s] = tag_of(pex);
          m_tgt[s] = tex & 32'hFFFF_FFFC; m_cnt[s] = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  // Branch resolved at pc with the model's own prediction carried down the pipe.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] tex, input logic tk);
    cyc(1'b0, pc, 1'b1, 1'b0, pc, tex, tk, model_taken(pc), model_target(pc));
  endtask

  initial begin
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pt;
    logic [31:0] pf;
    logic        tk;
    logic        ptk;
    logic [31:0] ptt;
    pa = 32'h0040_0010;
    pb = 32'h0080_0010;
    @(negedge clk);
    cyc(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Cold start and wrap-around fall-through
    cyc(1'b0, pa, 1'b0, 1'b0, pa, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("cold_target", pred_target_if, 32'h0040_0014);
    cyc(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, 32'd0);

    // Allocate on taken miss, then predicted taken
    cyc(1'b0, pa, 1'b1, 1'b0, pa, 32'h0040_0000, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, pa, 1'b0, 1'b0, pa, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("alloc_taken", {31'd0, pred_taken_if}, 32'd1);

    // Saturation up, down to sticky 00, and back up
    repeat (4) resolve(pa, 32'h0040_0000, 1'b1);
    repeat (4) resolve(pa, 32'h0040_0000, 1'b0);
    repeat (3) resolve(pa, 32'h0040_0000, 1'b1);

    // Index aliasing with same and different tag
    cyc(1'b0, pb, 1'b0, 1'b0, pb, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 32'h0040_0110, 1'b0, 1'b0, pa, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("alias_miss", {31'd0, pred_taken_if}, 32'd0);
    resolve(32'h0040_0110, 32'h0000_0800, 1'b0);
    cyc(1'b0, 32'h0040_0110, 1'b0, 1'b0, pa, 32'd0, 1'b0, 1'b0, 32'd0);

    // Stalled branch: no update, no mispredict
    cyc(1'b0, pa, 1'b1, 1'b1, pa, 32'h0040_0000, 1'b0, 1'b1, 32'h0040_0000);
    cyc(1'b0, pa, 1'b0, 1'b0, pa, 32'd0, 1'b0, 1'b0, 32'd0);

    // Target mismatch, then the same with reset in the update cycle
    pt = 32'h0040_0040;
    cyc(1'b0, pt, 1'b1, 1'b0, pt, 32'h0000_0100, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, pt, 1'b1, 1'b0, pt, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0100);
    cyc(1'b0, pt, 1'b0, 1'b0, pt, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, pt, 1'b1, 1'b0, pt, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0200);
    cyc(1'b0, pt, 1'b0, 1'b0, pt, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("rst_cnt_zero", mispredict_cnt, 32'd0);

    // Randomized traffic over a small set of aliasing PCs
    for (int n = 0; n < 800; n++) begin
      pt = 32'h0040_0000 | (32'($urandom_range(2)) << 8) | (32'($urandom_range(7)) << 2);
      if ($urandom_range(31) == 0) pt = 32'hFFFF_FFFC;
      pf = ($urandom_range(1) == 0) ? pt
           : 32'h0040_0000 | (32'($urandom_range(2)) << 8) | (32'($urandom_range(7)) << 2);
      tk  = 1'($urandom_range(1));
      ptk = model_taken(pt);
      ptt = model_target(pt);
      if ($urandom_range(3) == 0) begin
        ptk = 1'($urandom_range(1));
        ptt = 32'h0010_0000 | (32'($urandom_range(3)) << 4);
      end
      cyc(1'($urandom_range(63) == 0), pf, 1'($urandom_range(3) != 0),
          1'($urandom_range(7) == 0), pt, 32'h0010_0000 | (32'($urandom_range(3)) << 4),
          tk, ptk, ptt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
